// File: rtl/fetch_stage.sv
// fetch_stage: PC register, word-addressed instruction memory and IF/ID register
// with stall hold, branch redirect (one bubble) and a valid-fetch counter.
`default_nettype none

module fetch_stage #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [31:0] BUBBLE     = 32'h0000_0013
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          branch_taken,
  input  logic [63:0]                   branch_target,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [63:0]                   pc,
  output logic [63:0]                   ifid_pc,
  output logic [31:0]                   ifid_instr,
  output logic                          ifid_valid,
  output logic [31:0]                   fetch_count
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  logic [31:0]   imem_q [IMEM_DEPTH];

  logic [63:0]   pc_q,          pc_d;
  logic [63:0]   ifid_pc_q,     ifid_pc_d;
  logic [31:0]   ifid_instr_q,  ifid_instr_d;
  logic          ifid_valid_q,  ifid_valid_d;
  logic [31:0]   fetch_count_q, fetch_count_d;

  logic          in_range;
  logic [AW-1:0] widx;
  logic [31:0]   fetch_word;
  logic [63:0]   redirect_pc;

  // The array has no reset: its contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (imem_we) begin
      imem_q[imem_waddr] <= imem_wdata;
    end
  end

  // Any nonzero word-index bit above the array width means out of range.
  assign in_range    = (pc_q[63:AW+2] == '0);
  assign widx        = pc_q[AW+1:2];
  assign fetch_word  = in_range ? imem_q[widx] : BUBBLE;
  assign redirect_pc = branch_target & ~64'h3;

  always_comb begin
    pc_d          = pc_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;
    if (branch_taken) begin
      pc_d         = redirect_pc;
      ifid_pc_d    = pc_q;
      ifid_instr_d = BUBBLE;
      ifid_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d          = pc_q + 64'd4;
      ifid_pc_d     = pc_q;
      ifid_instr_d  = fetch_word;
      ifid_valid_d  = in_range;
      fetch_count_d = fetch_count_q + {31'd0, in_range};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      ifid_pc_q     <= 64'd0;
      ifid_instr_q  <= BUBBLE;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc          = pc_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_valid  = ifid_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that sits directly upstream of the 64-bit `pipeline` datapath and produces the `old_PC` and instruction it consumes. It holds the program counter, an internal word-addressed instruction memory loaded through a write port, and the IF/ID pipeline register. It also handles stall (hold) and branch redirect (flush with bubble insertion). It counts valid fetches for bench-side throughput checks.

## Interface
Parameters:
- `IMEM_DEPTH`, 64: number of 32-bit instruction words; power of two, ≥ 2.
- `RESET_PC`, 64'h0: PC value loaded on reset; low 2 bits must be 0.
- `BUBBLE`, 32'h0000_0013: instruction inserted on flush or out-of-range fetch.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `stall`  in  1  when 1, hold PC and the IF/ID register.
- `branch_taken`  in  1  redirect request from downstream.
- `branch_target`  in  64  redirect address; bits [1:0] are ignored and treated as 0.
- `imem_we`  in  1  instruction-memory write enable.
- `imem_waddr`  in  $clog2(IMEM_DEPTH)  word index to write.
- `imem_wdata`  in  32  instruction word to write.
- `pc`  out  64  current fetch PC.
- `ifid_pc`  out  64  PC of the instruction held in IF/ID.
- `ifid_instr`  out  32  instruction held in IF/ID.
- `ifid_valid`  out  1  1 when IF/ID holds a real instruction, 0 for a bubble.
- `fetch_count`  out  32  number of valid instructions latched into IF/ID; wraps modulo 2^32.

## Operation
- Word index: `widx = pc[63:2]`. The address is in range iff `widx < IMEM_DEPTH`.
- Instruction read is combinational from the array. Result: `imem[widx]` when in range, otherwise `BUBBLE`.
- Per rising edge, highest priority first:
  1. **branch_taken = 1** (overrides `stall`):
     - `pc <= {branch_target[63:2], 2'b00}`.
     - IF/ID <= `{ifid_pc: pc, ifid_instr: BUBBLE, ifid_valid: 0}`.
     - `fetch_count` unchanged.
  2. **stall = 1**: `pc`, IF/ID and `fetch_count` all hold.
  3. **Normal fetch**:
     - `pc <= pc + 4`, wrapping modulo 2^64.
     - IF/ID <= `{pc, fetched word, in_range}`.
     - `fetch_count` increments only when in range.
- An out-of-range fetch does not halt the stage. The PC keeps advancing and bubbles are emitted with `ifid_valid = 0`.
- Memory write:
  - Synchronous: `imem[imem_waddr] <= imem_wdata` on the edge when `imem_we = 1`.
  - Independent of `stall` and `branch_taken`.
  - Memory contents are not cleared by reset; they are undefined until written.
- Write/read collision (same word written and fetched on the same edge): IF/ID captures the OLD contents. The new word is visible from the next cycle.

## Timing
- Reset values, applied asynchronously and immediately on `reset` = 0:
  - `pc = RESET_PC`
  - `ifid_pc = 0`
  - `ifid_instr = BUBBLE`
  - `ifid_valid = 0`
  - `fetch_count = 0`
- Reset asserted mid-operation discards any in-flight IF/ID content and pending redirect. The array is untouched.
- After reset deasserts, the first rising edge is the first fetch. Latency from `pc` to IF/ID outputs is exactly 1 cycle.
- Steady state with no stall or branch: one instruction per cycle, with `ifid_pc` advancing by 4 each cycle.
- Branch:
  - The target appears on `pc` 1 cycle after the `branch_taken` edge.
  - Its instruction appears in IF/ID 2 cycles after.
  - Exactly one bubble is inserted.
- `branch_taken` held for several cycles re-redirects on every cycle. IF/ID shows a bubble each of those cycles.
- Stall held for N cycles freezes all outputs for N cycles. Fetch resumes on the first edge with `stall` = 0.
- PC wrap: `pc = 64'hFFFF_FFFF_FFFF_FFFC` → next `pc = 0`.

## Test plan
- **Reset, then sequential fetch.**
  - Stimulus: load words 0..3 = 32'h11, 22, 33, 44 under reset; release reset; run 4 edges.
  - Required: IF/ID shows (0,11,1), (4,22,1), (8,33,1), (C,44,1); `pc = 16`; `fetch_count = 4`.
- **Stall.**
  - Stimulus: `stall` = 1 for 3 cycles after 2 fetches.
  - Required: `pc = 8`, `ifid = (4,22,1)` and `fetch_count = 2` held for 3 cycles. The next edge gives `(8,33,1)`.
- **Branch beats stall.**
  - Stimulus: `stall` = 1 and `branch_taken` = 1 with `branch_target = 64'h0E` in the same cycle.
  - Required: `pc = 0xC`, `ifid_valid = 0`, `ifid_instr = BUBBLE`. The next edge gives `ifid = (C,44,1)`.
- **Out-of-range fetch.**
  - Stimulus: `IMEM_DEPTH = 64`; branch to `0x100`.
  - Required: the following fetch gives `ifid = (100,BUBBLE,0)`, `pc = 0x104`, `fetch_count` unchanged.
- **Write/read collision.**
  - Stimulus: write word 2 = 32'hAA on the edge that fetches `pc = 8`.
  - Required: `ifid_instr = 33`. A later re-fetch of `0x8` returns `AA`.
- **Asynchronous reset mid-run.**
  - Stimulus: drop `reset` between clock edges while `pc = 0x10`.
  - Required: `pc = RESET_PC`, `ifid_valid = 0`, `fetch_count = 0` immediately, without waiting for a clock edge. The previously loaded memory word 0 is fetched correctly after release.
